// File: rtl/mux_arbiter_8.sv
// mux_arbiter_8: round-robin arbiter and sequencer for a shared 8:1 mux.
// Eight sources present burst requests. One source is granted at a time.
// Its words are captured into a single valid/ready output register.
// A grant ends on the source's last word, after MAX_BURST beats, or when
// the source drops its request.

module mux_arbiter_8 #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:1]        req,
    input  logic [8:1]        last,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] A2,
    input  logic [DATA_W-1:0] A3,
    input  logic [DATA_W-1:0] A4,
    input  logic [DATA_W-1:0] A5,
    input  logic [DATA_W-1:0] A6,
    input  logic [DATA_W-1:0] A7,
    input  logic [DATA_W-1:0] A8,
    input  logic              out_ready,
    output logic [8:1]        grant,
    output logic [2:0]        chooser,
    output logic [8:1]        ack,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // One-hot code for a zero-based source index (bit j = source j+1).
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        grant_r;
    logic [2:0]        chooser_r;
    logic [2:0]        rr_idx_r;      // zero-based index of the last served source
    logic [3:0]        beat_cnt_r;
    logic [DATA_W-1:0] out_r;
    logic              out_valid_r;
    logic              busy_r;

    logic [7:0]        req_s;         // bit j is source j+1
    logic [7:0]        last_s;
    logic [DATA_W-1:0] mux_s;
    logic              win_found_s;
    logic [2:0]        win_idx_s;
    logic              req_g_s;
    logic              last_g_s;
    logic              beat_s;
    logic              term_s;
    logic [3:0]        beat_cnt_inc_s;

    assign req_s  = req;
    assign last_s = last;

    // Shared 8:1 data mux steered by the registered select.
    always_comb begin
        mux_s = {DATA_W{1'b0}};
        case (chooser_r)
            3'd0:    mux_s = A1;
            3'd1:    mux_s = A2;
            3'd2:    mux_s = A3;
            3'd3:    mux_s = A4;
            3'd4:    mux_s = A5;
            3'd5:    mux_s = A6;
            3'd6:    mux_s = A7;
            3'd7:    mux_s = A8;
            default: mux_s = {DATA_W{1'b0}};
        endcase
    end

    // Round-robin search starting just after the last served source.
    // The last served source is checked last, so it has the lowest priority.
    always_comb begin
        logic [2:0] cand;
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        cand        = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = rr_idx_r + 3'(i);
            if (!win_found_s && req_s[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Beat and termination conditions for the current grant.
    // No beat is taken in a reset cycle, so no ack is issued then.
    always_comb begin
        req_g_s        = req_s[chooser_r];
        last_g_s       = last_s[chooser_r];
        beat_cnt_inc_s = beat_cnt_r + 4'd1;
        if ((state_r == ST_XFER) && !reset) begin
            beat_s = req_g_s && (!out_valid_r || out_ready);
        end else begin
            beat_s = 1'b0;
        end
        if (state_r == ST_XFER) begin
            term_s = !req_g_s ||
                     (beat_s && (last_g_s || (beat_cnt_inc_s == BURST_LIMIT)));
        end else begin
            term_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE/XFER sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (term_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with a registered busy flag that mirrors XFER.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_XFER);
        end
    end

    // Grant, select, round-robin pointer and beat counter.
    // The select only moves when a new grant is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r    <= 8'h00;
            chooser_r  <= 3'd0;
            rr_idx_r   <= 3'd7;
            beat_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        grant_r    <= onehot8(win_idx_s);
                        chooser_r  <= win_idx_s;
                        rr_idx_r   <= win_idx_s;
                        beat_cnt_r <= 4'd0;
                    end else begin
                        grant_r <= 8'h00;
                    end
                end
                ST_XFER: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_inc_s;
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                    if (term_s) begin
                        grant_r <= 8'h00;
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                default: grant_r <= 8'h00;
            endcase
        end
    end

    // Output register: capture on a beat, release when the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r       <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (beat_s) begin
            out_r       <= mux_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign grant     = grant_r;
    assign chooser   = chooser_r;
    assign ack       = beat_s ? grant_r : 8'h00;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mux_arbiter_8.sv
// Self-checking bench for mux_arbiter_8: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.

module tb_mux_arbiter_8;

    localparam int DW   = 16;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:1]    req;
    logic [8:1]    last;
    logic [DW-1:0] a [1:8];
    logic          out_ready;
    logic [8:1]    grant;
    logic [2:0]    chooser;
    logic [8:1]    ack;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // source behaviour
    int          src_act [1:8];
    int          src_rem [1:8];
    int          src_seq [1:8];
    logic [15:0] src_base[1:8];
    int          start_pct;
    int          len_max;
    bit          drop_en;

    // reference model
    int          m_g;      // granted source 1..8, 0 when idle
    int          m_ch;
    int          m_rr;
    int          m_cnt;
    logic [15:0] m_out;
    bit          m_ov;
    logic [8:1]  obs_ack;

    // clock
    always #5 clk = ~clk;

    mux_arbiter_8 #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last),
        .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]),
        .A5(a[5]), .A6(a[6]), .A7(a[7]), .A8(a[8]),
        .out_ready(out_ready), .grant(grant), .chooser(chooser), .ack(ack),
        .out(out), .out_valid(out_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:1] src_bit(input int k);
        logic [8:1] v;
        v    = 8'h00;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [8:1] model_ack();
        if (!reset && m_g != 0 && req[m_g] && (!m_ov || out_ready)) return src_bit(m_g);
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_g = 0; m_ch = 0; m_rr = 8; m_cnt = 0; m_out = 16'h0000; m_ov = 1'b0;
    endtask

    task automatic model_edge(input logic [8:1] exp_ack);
        bit beat;
        int s;
        beat = (exp_ack != 8'h00);
        if (reset) begin
            model_reset();
            return;
        end
        if (beat) begin
            m_out = a[m_g];
            m_ov  = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (m_g == 0) begin
            for (int i = 1; i <= 8; i++) begin
                s = ((m_rr + i - 1) % 8) + 1;
                if (req[s]) begin
                    m_g = s; m_ch = s - 1; m_rr = s; m_cnt = 0;
                    break;
                end
            end
        end else if (!req[m_g]) begin
            m_g = 0;
        end else if (beat) begin
            m_cnt++;
            if (last[m_g] || m_cnt == MAXB) m_g = 0;
        end
    endtask

    task automatic src_drive();
        for (int k = 1; k <= 8; k++) begin
            if (src_act[k] == 0 && start_pct > 0 && $urandom_range(0, 99) < start_pct) begin
                src_act[k] = 1;
                src_rem[k] = $urandom_range(1, len_max);
            end
            if (src_act[k] != 0 && drop_en && $urandom_range(0, 19) == 0) src_act[k] = 0;
            req[k]  = (src_act[k] != 0);
            last[k] = (src_act[k] != 0) && (src_rem[k] == 1);
            a[k]    = src_base[k] + 16'(src_seq[k]);
        end
    endtask

    task automatic src_advance(input logic [8:1] exp_ack);
        for (int k = 1; k <= 8; k++) begin
            if (exp_ack[k]) begin
                src_seq[k] = src_seq[k] + 1;
                src_rem[k] = src_rem[k] - 1;
                if (src_rem[k] <= 0) src_act[k] = 0;
            end
        end
    endtask

    task automatic cycle();
        logic [8:1] ea;
        logic [8:1] eg;
        src_drive();
        #1;
        ea      = model_ack();
        eg      = (m_g == 0) ? 8'h00 : src_bit(m_g);
        obs_ack = ack;
        chk("ack", ack, ea);
        chk("grant", grant, eg);
        chk("chooser", chooser, m_ch);
        chk("out", out, m_out);
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, m_g != 0);
        @(posedge clk);
        model_edge(ea);
        src_advance(ea);
        @(negedge clk);
    endtask

    task automatic clear_sources();
        for (int k = 1; k <= 8; k++) src_act[k] = 0;
    endtask

    initial begin
        int n;
        int exp_src;
        logic [8:1] prev;

        reset = 1'b1; out_ready = 1'b1; req = 8'h00; last = 8'h00;
        start_pct = 0; len_max = 4; drop_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            src_act[k] = 0; src_rem[k] = 0; src_seq[k] = 0;
            src_base[k] = 16'(k * 16'h1000);
            a[k] = 16'h0000;
        end
        @(negedge clk);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        cycle();                         // reset values
        reset = 1'b0;

        // single burst from source 3
        src_base[3] = 16'h00A1; src_seq[3] = 0; src_rem[3] = 3; src_act[3] = 1;
        cycle();
        chk("sb_grant", grant, 8'b0000_0100);
        chk("sb_chooser", chooser, 3'd2);
        for (int c = 0; c < 3; c++) cycle();
        chk("sb_idle", busy, 1'b0);
        chk("sb_last_word", out, 16'h00A3);
        for (int c = 0; c < 2; c++) cycle();

        // round robin after reset: 1..8 then 1
        reset = 1'b1; cycle(); reset = 1'b0;
        start_pct = 100; len_max = 1;
        prev = 8'h00; n = 0; exp_src = 1;
        for (int c = 0; c < 60 && n < 9; c++) begin
            cycle();
            if (grant != 8'h00 && prev == 8'h00) begin
                chk("rr_order", chooser + 1, exp_src);
                exp_src = (exp_src % 8) + 1;
                n++;
            end
            prev = grant;
        end
        chk("rr_count", n, 9);
        start_pct = 0; clear_sources();
        for (int c = 0; c < 3; c++) cycle();

        // forced rotation after MAX_BURST beats
        src_act[5] = 1; src_rem[5] = 100; src_act[6] = 1; src_rem[6] = 1;
        n = 0;
        for (int c = 0; c < 40 && grant != src_bit(6); c++) begin
            cycle();
            if (obs_ack[5]) n++;
        end
        chk("mb_acks5", n, MAXB);
        chk("mb_grant6", grant, src_bit(6));
        clear_sources();
        for (int c = 0; c < 3; c++) cycle();

        // back-pressure mid-burst
        src_act[2] = 1; src_rem[2] = 6;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c >= 3 && c < 6) ? 1'b0 : 1'b1;
            cycle();
            if (c >= 3 && c < 6) chk("bp_noack", obs_ack, 8'h00);
        end
        out_ready = 1'b1;
        clear_sources();
        for (int c = 0; c < 3; c++) cycle();

        // request drop from source 2: source 3 is next
        src_act[2] = 1; src_rem[2] = 10;
        for (int c = 0; c < 3; c++) cycle();
        src_act[2] = 0;
        src_act[1] = 1; src_rem[1] = 1; src_act[3] = 1; src_rem[3] = 1;
        cycle();
        chk("drop_grant0", grant, 8'h00);
        cycle();
        chk("drop_next", grant, src_bit(3));
        for (int c = 0; c < 6; c++) cycle();
        clear_sources();

        // reset mid-burst with a pending word
        src_act[4] = 1; src_rem[4] = 10;
        for (int c = 0; c < 3; c++) cycle();
        chk("rst_pre_ov", out_valid, 1'b1);
        reset = 1'b1; src_act[4] = 0;
        cycle();
        reset = 1'b0;
        chk("rst_grant", grant, 8'h00);
        chk("rst_ov", out_valid, 1'b0);
        src_act[6] = 1; src_rem[6] = 1; src_act[3] = 1; src_rem[3] = 1;
        cycle();
        chk("rst_first", grant, src_bit(3));
        for (int c = 0; c < 6; c++) cycle();

        // random traffic
        for (int k = 1; k <= 8; k++) src_base[k] = 16'($urandom);
        start_pct = 15; len_max = 7; drop_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
